// File: rtl/sel_decode_pkg.sv
// Shared types and constants for the selector decode monitor: FSM states,
// the code type, the default code and the sparse selector map.
package sel_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [2:0] code_t;

  localparam code_t CODE_DEFAULT = 3'd7;

  // Selector values that map to codes 0..4, in code order.
  localparam int unsigned SEL_MAP0 = 0;
  localparam int unsigned SEL_MAP1 = 1;
  localparam int unsigned SEL_MAP2 = 2;
  localparam int unsigned SEL_MAP3 = 4;
  localparam int unsigned SEL_MAP4 = 5;

endpackage

// File: rtl/sel_decode_monitor_if.sv
// Bundle of the selector input stream, the code output stream, done request
// and the statistics/debug outputs of sel_decode_monitor.
interface sel_decode_monitor_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  import sel_decode_pkg::*;

  // Both streams use strict valid/ready: a transfer happens in a cycle where
  // valid&ready is 1; a producer holds valid and data stable until then, and
  // ready never depends combinationally on the same-side valid.
  logic             sel_valid_i;
  logic             sel_ready_o;
  logic [SEL_W-1:0] sel_i;
  logic             done_i;
  logic             code_valid_o;
  logic             code_ready_i;
  code_t            code_o;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic [CNT_W-1:0] mismatch_cnt_o;
  logic [1:0]       state_o;

  modport slave (
    input  sel_valid_i, sel_i, done_i, code_ready_i,
    output sel_ready_o, code_valid_o, code_o,
           hit_cnt_o, miss_cnt_o, mismatch_cnt_o, state_o
  );

  modport master (
    output sel_valid_i, sel_i, done_i, code_ready_i,
    input  sel_ready_o, code_valid_o, code_o,
           hit_cnt_o, miss_cnt_o, mismatch_cnt_o, state_o
  );

endinterface

// File: rtl/sel_decode_core.sv
// Combinational sparse selector decoder. STYLE picks a case statement (0) or
// an if-else chain (1) so two independent implementations can be compared.
module sel_decode_core
  import sel_decode_pkg::*;
#(
  parameter int SEL_W       = 3,
  parameter int STYLE       = 0,
  parameter bit HAS_DEFAULT = 1'b1
) (
  input  logic [SEL_W-1:0] i_sel,
  input  code_t            i_last,
  output code_t            o_code,
  output logic             o_hit
);

  code_t w_miss_code;
  assign w_miss_code = HAS_DEFAULT ? CODE_DEFAULT : i_last;

  // Full-width compares make any nonzero upper selector bit a miss.
  generate
    if (STYLE == 0) begin : g_case
      always_comb begin
        o_hit  = 1'b1;
        o_code = 3'd0;
        case (i_sel)
          SEL_W'(SEL_MAP0): o_code = 3'd0;
          SEL_W'(SEL_MAP1): o_code = 3'd1;
          SEL_W'(SEL_MAP2): o_code = 3'd2;
          SEL_W'(SEL_MAP3): o_code = 3'd3;
          SEL_W'(SEL_MAP4): o_code = 3'd4;
          default: begin
            o_hit  = 1'b0;
            o_code = w_miss_code;
          end
        endcase
      end
    end else begin : g_if
      always_comb begin
        o_hit  = 1'b1;
        o_code = 3'd0;
        if (i_sel == SEL_W'(SEL_MAP0)) begin
          o_code = 3'd0;
        end else if (i_sel == SEL_W'(SEL_MAP1)) begin
          o_code = 3'd1;
        end else if (i_sel == SEL_W'(SEL_MAP2)) begin
          o_code = 3'd2;
        end else if (i_sel == SEL_W'(SEL_MAP3)) begin
          o_code = 3'd3;
        end else if (i_sel == SEL_W'(SEL_MAP4)) begin
          o_code = 3'd4;
        end else begin
          o_hit  = 1'b0;
          o_code = w_miss_code;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sel_decode_monitor.sv
// Selector stream consumer: decodes each accepted selector into a one-entry
// output register, keeps hit/miss/disagreement statistics and a run FSM.
module sel_decode_monitor
  import sel_decode_pkg::*;
#(
  parameter int SEL_W       = 3,
  parameter int CNT_W       = 16,
  parameter bit HAS_DEFAULT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sel_decode_monitor_if.slave  sel_bus
);

  state_e           r_state;
  logic             r_valid;
  code_t            r_code;
  code_t            r_last;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;
  logic [CNT_W-1:0] r_mm;

  logic             w_ready;
  logic             w_accept;
  logic             w_drain;
  code_t            w_code_case;
  code_t            w_code_if;
  logic             w_hit_case;
  logic             w_hit_if;
  logic             w_disagree;

  // Ready only looks at state and the output slot, never at sel_valid_i.
  assign w_ready  = ((r_state == ST_IDLE) || (r_state == ST_RUN)) &&
                    (!r_valid || sel_bus.code_ready_i);
  assign w_accept = sel_bus.sel_valid_i && w_ready;
  assign w_drain  = r_valid && sel_bus.code_ready_i;

  sel_decode_core #(
    .SEL_W       (SEL_W),
    .STYLE       (0),
    .HAS_DEFAULT (HAS_DEFAULT)
  ) u_case (
    .i_sel  (sel_bus.sel_i),
    .i_last (r_last),
    .o_code (w_code_case),
    .o_hit  (w_hit_case)
  );

  sel_decode_core #(
    .SEL_W       (SEL_W),
    .STYLE       (1),
    .HAS_DEFAULT (HAS_DEFAULT)
  ) u_if (
    .i_sel  (sel_bus.sel_i),
    .i_last (r_last),
    .o_code (w_code_if),
    .o_hit  (w_hit_if)
  );

  assign w_disagree = (w_code_case != w_code_if) || (w_hit_case != w_hit_if);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_code  <= 3'd0;
      r_last  <= 3'd0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_mm    <= '0;
    end else begin
      // An accept reloads the slot even when it drains in the same cycle.
      if (w_accept) begin
        r_valid <= 1'b1;
        r_code  <= w_code_case;
        r_last  <= w_code_case;
        if (w_hit_case) begin
          if (r_hit != '1) r_hit <= r_hit + CNT_W'(1);
        end else begin
          if (r_miss != '1) r_miss <= r_miss + CNT_W'(1);
        end
        if (w_disagree && (r_mm != '1)) r_mm <= r_mm + CNT_W'(1);
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (sel_bus.done_i)  r_state <= ST_DRAIN;
          else if (w_accept)   r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (sel_bus.done_i)  r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_valid || w_drain) r_state <= ST_DONE;
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

  assign sel_bus.sel_ready_o    = w_ready;
  assign sel_bus.code_valid_o   = r_valid;
  assign sel_bus.code_o         = r_code;
  assign sel_bus.hit_cnt_o      = r_hit;
  assign sel_bus.miss_cnt_o     = r_miss;
  assign sel_bus.mismatch_cnt_o = r_mm;
  assign sel_bus.state_o        = r_state;

endmodule

// File: tb/tb_sel_decode_monitor.sv
// Bench for sel_decode_monitor: three instances (default map, repeat-last map,
// 2-bit counters) share one directed stimulus and a per-instance code scoreboard.
module tb_sel_decode_monitor;

  logic       clk;
  logic       tb_rst;
  logic       tb_sel_valid;
  logic [2:0] tb_sel;
  logic       tb_done;
  logic       tb_code_ready;

  int n_tests;
  int n_fail;

  sel_decode_monitor_if #(.SEL_W(3), .CNT_W(16)) if0 ();
  sel_decode_monitor_if #(.SEL_W(3), .CNT_W(16)) if1 ();
  sel_decode_monitor_if #(.SEL_W(3), .CNT_W(2))  if2 ();

  assign if0.sel_valid_i  = tb_sel_valid;
  assign if0.sel_i        = tb_sel;
  assign if0.done_i       = tb_done;
  assign if0.code_ready_i = tb_code_ready;
  assign if1.sel_valid_i  = tb_sel_valid;
  assign if1.sel_i        = tb_sel;
  assign if1.done_i       = tb_done;
  assign if1.code_ready_i = tb_code_ready;
  assign if2.sel_valid_i  = tb_sel_valid;
  assign if2.sel_i        = tb_sel;
  assign if2.done_i       = tb_done;
  assign if2.code_ready_i = tb_code_ready;

  sel_decode_monitor #(.SEL_W(3), .CNT_W(16), .HAS_DEFAULT(1'b1)) u_def (
    .clk_i(clk), .rst_i(tb_rst), .sel_bus(if0));
  sel_decode_monitor #(.SEL_W(3), .CNT_W(16), .HAS_DEFAULT(1'b0)) u_nodef (
    .clk_i(clk), .rst_i(tb_rst), .sel_bus(if1));
  sel_decode_monitor #(.SEL_W(3), .CNT_W(2), .HAS_DEFAULT(1'b1)) u_sat (
    .clk_i(clk), .rst_i(tb_rst), .sel_bus(if2));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance observation, counters zero-extended to 16 bits.
  logic        obs_ready [3];
  logic        obs_cv    [3];
  logic [2:0]  obs_code  [3];
  logic [15:0] obs_hit   [3];
  logic [15:0] obs_miss  [3];
  logic [15:0] obs_mm    [3];
  logic [1:0]  obs_state [3];

  assign obs_ready[0] = if0.sel_ready_o;     assign obs_ready[1] = if1.sel_ready_o;
  assign obs_ready[2] = if2.sel_ready_o;
  assign obs_cv[0]    = if0.code_valid_o;    assign obs_cv[1]    = if1.code_valid_o;
  assign obs_cv[2]    = if2.code_valid_o;
  assign obs_code[0]  = if0.code_o;          assign obs_code[1]  = if1.code_o;
  assign obs_code[2]  = if2.code_o;
  assign obs_hit[0]   = if0.hit_cnt_o;       assign obs_hit[1]   = if1.hit_cnt_o;
  assign obs_hit[2]   = 16'(if2.hit_cnt_o);
  assign obs_miss[0]  = if0.miss_cnt_o;      assign obs_miss[1]  = if1.miss_cnt_o;
  assign obs_miss[2]  = 16'(if2.miss_cnt_o);
  assign obs_mm[0]    = if0.mismatch_cnt_o;  assign obs_mm[1]    = if1.mismatch_cnt_o;
  assign obs_mm[2]    = 16'(if2.mismatch_cnt_o);
  assign obs_state[0] = if0.state_o;         assign obs_state[1] = if1.state_o;
  assign obs_state[2] = if2.state_o;

  // Scoreboard and reference model state
  logic [2:0] exp_q0 [$];
  logic [2:0] exp_q1 [$];
  logic [2:0] exp_q2 [$];
  logic       m_valid;
  logic [1:0] m_state;
  logic [2:0] m_last [3];

  function automatic logic [2:0] ref_code(input logic [2:0] s, input logic [2:0] last,
                                          input bit has_def);
    logic [2:0] r;
    case (s)
      3'd0: r = 3'd0;
      3'd1: r = 3'd1;
      3'd2: r = 3'd2;
      3'd4: r = 3'd3;
      3'd5: r = 3'd4;
      default: r = has_def ? 3'd7 : last;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input int k, input logic [2:0] c);
    case (k)
      0: exp_q0.push_back(c);
      1: exp_q1.push_back(c);
      default: exp_q2.push_back(c);
    endcase
  endtask

  task automatic sb_front(input int k, output logic [2:0] c, output bit ok);
    ok = 1'b0;
    c  = 3'd0;
    case (k)
      0: if (exp_q0.size() > 0) begin c = exp_q0[0]; ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin c = exp_q1[0]; ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin c = exp_q2[0]; ok = 1'b1; end
    endcase
  endtask

  task automatic sb_drop(input int k);
    case (k)
      0: if (exp_q0.size() > 0) void'(exp_q0.pop_front());
      1: if (exp_q1.size() > 0) void'(exp_q1.pop_front());
      default: if (exp_q2.size() > 0) void'(exp_q2.pop_front());
    endcase
  endtask

  // Runs at the negedge: compares handshake outputs and the held code against
  // the model, then advances the model to what the next posedge will do.
  task automatic monitor();
    bit ready, drain, accept, ok;
    logic [2:0] c, f;
    if (tb_rst) begin
      m_valid = 1'b0;
      m_state = 2'd0;
      for (int k = 0; k < 3; k++) m_last[k] = 3'd0;
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
      return;
    end
    ready  = (m_state < 2'd2) && (!m_valid || tb_code_ready);
    drain  = m_valid && tb_code_ready;
    accept = tb_sel_valid && ready;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sel_ready[%0d]", k), 32'(obs_ready[k]), 32'(ready));
      check($sformatf("code_valid[%0d]", k), 32'(obs_cv[k]), 32'(m_valid));
      check($sformatf("state[%0d]", k), 32'(obs_state[k]), 32'(m_state));
      if (m_valid) begin
        sb_front(k, f, ok);
        n_tests++;
        assert (ok) else begin
          n_fail++;
          $error("FAIL sb_empty[%0d]: observed code %0h with no expected entry", k, obs_code[k]);
        end
        if (ok) check($sformatf("code[%0d]", k), 32'(obs_code[k]), 32'(f));
        if (drain) sb_drop(k);
      end
    end
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        c = ref_code(tb_sel, m_last[k], k != 1);
        sb_push(k, c);
        m_last[k] = c;
      end
    end
    case (m_state)
      2'd0: if (tb_done) m_state = 2'd2; else if (accept) m_state = 2'd1;
      2'd1: if (tb_done) m_state = 2'd2;
      2'd2: if (!m_valid || drain) m_state = 2'd3;
      default: m_state = 2'd3;
    endcase
    if (accept)     m_valid = 1'b1;
    else if (drain) m_valid = 1'b0;
  endtask

  // Driver: inputs are set before calling; checks at negedge, returns #1 after posedge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input int k, input int hit, input int miss, input int mm);
    check($sformatf("hit_cnt[%0d]", k),  32'(obs_hit[k]),  32'(hit));
    check($sformatf("miss_cnt[%0d]", k), 32'(obs_miss[k]), 32'(miss));
    check($sformatf("mm_cnt[%0d]", k),   32'(obs_mm[k]),   32'(mm));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    m_valid       = 1'b0;
    m_state       = 2'd0;
    tb_rst        = 1'b1;
    tb_sel_valid  = 1'b0;
    tb_sel        = 3'd0;
    tb_done       = 1'b0;
    tb_code_ready = 1'b1;
    for (int k = 0; k < 3; k++) m_last[k] = 3'd0;
    tick();
    tick();
    tb_rst = 1'b0;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_code[%0d]", k), 32'(obs_code[k]), 32'd0);
      check($sformatf("rst_valid[%0d]", k), 32'(obs_cv[k]), 32'd0);
      check($sformatf("rst_state[%0d]", k), 32'(obs_state[k]), 32'd0);
      chk_cnt(k, 0, 0, 0);
    end

    // Sweep 0..7 with ready high
    for (int s = 0; s < 8; s++) begin
      tb_sel_valid = 1'b1;
      tb_sel       = 3'(s);
      tick();
    end
    tb_sel_valid = 1'b0;
    tick();
    chk_cnt(0, 5, 3, 0);
    chk_cnt(1, 5, 3, 0);
    chk_cnt(2, 3, 3, 0);
    check("sweep_state", 32'(obs_state[0]), 32'd1);

    // Stall: one accept, then four cycles held
    tb_code_ready = 1'b0;
    tb_sel_valid  = 1'b1;
    tb_sel        = 3'd1;
    for (int i = 0; i < 5; i++) tick();
    check("stall_code", 32'(obs_code[0]), 32'd1);
    check("stall_ready", 32'(obs_ready[0]), 32'd0);
    chk_cnt(0, 6, 3, 0);
    tb_code_ready = 1'b1;
    tb_sel = 3'd2; tick();
    tb_sel = 3'd4; tick();
    tb_sel = 3'd5; tick();
    tb_sel_valid = 1'b0;
    tick();
    chk_cnt(0, 9, 3, 0);
    chk_cnt(1, 9, 3, 0);
    chk_cnt(2, 3, 3, 0);

    // done_i with a pending code and downstream stalled
    tb_code_ready = 1'b0;
    tb_sel_valid  = 1'b1;
    tb_sel        = 3'd0;
    tick();
    tb_done = 1'b1;
    tb_sel  = 3'd1;
    tick();
    tb_done = 1'b0;
    check("drain_state", 32'(obs_state[0]), 32'd2);
    check("drain_ready", 32'(obs_ready[0]), 32'd0);
    tick();
    tb_code_ready = 1'b1;
    tick();
    check("done_state", 32'(obs_state[0]), 32'd3);
    check("done_valid", 32'(obs_cv[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tb_sel = 3'($urandom_range(0, 7));
      tick();
    end
    chk_cnt(0, 10, 3, 0);
    check("done_hold", 32'(obs_state[0]), 32'd3);

    // Reset with a pending code
    tb_rst = 1'b1; tb_sel_valid = 1'b0; tick();
    tb_rst = 1'b0;
    tb_code_ready = 1'b0;
    tb_sel_valid  = 1'b1;
    tb_sel        = 3'd2;
    tick();
    check("pend_valid", 32'(obs_cv[0]), 32'd1);
    tb_rst = 1'b1; tb_sel_valid = 1'b0; tick();
    tb_rst = 1'b0;
    check("rst_mid_valid", 32'(obs_cv[0]), 32'd0);
    check("rst_mid_state", 32'(obs_state[0]), 32'd0);
    chk_cnt(0, 0, 0, 0);
    chk_cnt(1, 0, 0, 0);

    // Last-code register cleared: unmapped selector repeats 0
    tb_code_ready = 1'b1;
    tb_sel_valid  = 1'b1;
    tb_sel        = 3'd7;
    tick();
    check("last_clr_nodef", 32'(obs_code[1]), 32'd0);
    check("last_clr_def", 32'(obs_code[0]), 32'd7);

    // done_i together with an accept in RUN
    tb_sel  = 3'd4;
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tb_sel_valid = 1'b0;
    check("done_acc_state", 32'(obs_state[0]), 32'd2);
    check("done_acc_code", 32'(obs_code[0]), 32'd3);
    chk_cnt(0, 1, 1, 0);
    chk_cnt(2, 1, 1, 0);
    tick();
    check("done_acc_final", 32'(obs_state[0]), 32'd3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
